// File: rtl/projeto_200917_qsys_dado_master_if.sv
// rtl/projeto_200917_qsys_dado_master_if.sv - Avalon-MM bus between the dice master and the PIO slave
interface projeto_200917_qsys_dado_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic              avm_read;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_write, avm_read, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_write, avm_read, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/projeto_200917_qsys_dado_master.sv
// rtl/projeto_200917_qsys_dado_master.sv - dice master writing 1..6 to the PIO slave on tick or roll
// Optional readback verification: define READBACK_CHECK_EN.
module projeto_200917_qsys_dado_master #(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 32,
    parameter int VAL_W       = 4,
    parameter int TARGET_ADDR = 0,
    parameter int PERIOD      = 50000000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic                                      roll,
    input  logic                                      clear_flags,
    projeto_200917_qsys_dado_master_if.master         avm,
    output logic [VAL_W-1:0]                          value,
    output logic                                      busy,
    output logic                                      mismatch,
    output logic                                      overrun
);
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_CHECK} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick, ev;
    logic [VAL_W-1:0]  next_val, roll_val;
    logic              write_d, read_d, ovr_set;

    assign tick     = enable && (tick_cnt == CNT_W'(PERIOD - 1));
    assign ev       = tick | roll;
    assign roll_val = (value == VAL_W'(6) || value == '0) ? VAL_W'(1) : value + VAL_W'(1);
    assign busy     = (state != S_IDLE);

    assign avm.avm_address   = ADDR_W'(TARGET_ADDR);
    assign avm.avm_writedata = {{(DATA_W-VAL_W){1'b0}}, next_val};

    always_ff @(posedge clk) begin
        if (reset || !enable || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            avm.avm_write <= 1'b0;
            avm.avm_read  <= 1'b0;
            value         <= '0;
            next_val      <= '0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_n;
            avm.avm_write <= write_d;
            avm.avm_read  <= read_d;
            if (state == S_IDLE && ev)
                next_val <= roll_val;
            if (state == S_WRITE && !avm.avm_waitrequest)
                value <= next_val;
            // a new overrun in the clearing cycle must not be lost
            if (ovr_set)
                overrun <= 1'b1;
            else if (clear_flags)
                overrun <= 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (ev) state_n = S_WRITE;
`ifdef READBACK_CHECK_EN
            S_WRITE: if (!avm.avm_waitrequest) state_n = S_READ;
            S_READ:  if (!avm.avm_waitrequest) state_n = S_CHECK;
            S_CHECK: state_n = S_IDLE;
`else
            S_WRITE: if (!avm.avm_waitrequest) state_n = S_IDLE;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // strobes are registered from the next state so they rise with state entry
    always_comb begin
        write_d = (state_n == S_WRITE);
`ifdef READBACK_CHECK_EN
        read_d  = (state_n == S_READ);
`else
        read_d  = 1'b0;
`endif
        ovr_set = ev && (state != S_IDLE);
    end

`ifdef READBACK_CHECK_EN
    logic [DATA_W-1:0] captured;

    always_ff @(posedge clk) begin
        if (reset) begin
            captured <= '0;
            mismatch <= 1'b0;
        end else begin
            if (state == S_READ && !avm.avm_waitrequest)
                captured <= avm.avm_readdata;
            if (state == S_CHECK && captured != {{(DATA_W-VAL_W){1'b0}}, value})
                mismatch <= 1'b1;
            else if (clear_flags)
                mismatch <= 1'b0;
        end
    end
`else
    assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_projeto_200917_qsys_dado_master.sv
// tb/tb_projeto_200917_qsys_dado_master.sv - transaction-level model check of the dice master
module tb_projeto_200917_qsys_dado_master;
    localparam int PERIOD = 4;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int VAL_W  = 4;
`ifdef READBACK_CHECK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int OP_W = 1, OP_R = 2, OP_C = 3;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, roll = 1'b0, clear_flags = 1'b0;
    logic [VAL_W-1:0] value;
    logic busy, mismatch, overrun;
    logic wait_r = 1'b0, corrupt = 1'b0;
    logic [3:0] pio;

    projeto_200917_qsys_dado_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

    projeto_200917_qsys_dado_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VAL_W(VAL_W), .TARGET_ADDR(0), .PERIOD(PERIOD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .roll(roll), .clear_flags(clear_flags),
        .avm(avm), .value(value), .busy(busy), .mismatch(mismatch), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // 4-bit PIO slave; optionally corrupts the readback of value 3
    assign avm.avm_waitrequest = wait_r;
    assign avm.avm_readdata    = (corrupt && pio == 4'd3) ? 32'h13 : {28'd0, pio};
    always @(posedge clk) begin
        if (reset) pio <= 4'd0;
        else if (avm.avm_write && !avm.avm_waitrequest) pio <= avm.avm_writedata[3:0];
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: a transaction is a queue of pending bus operations
    int          ops[$];
    int          m_cnt;
    logic [3:0]  m_val, m_next;
    logic        m_mis, m_ovr, m_valid = 1'b0;
    logic [31:0] m_cap;
    logic [3:0]  wlog[$];
    bit          m_tk, m_ev, m_bz, m_ms;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, ops.size() != 0);
            chk("avm_write", avm.avm_write, ops.size() != 0 && ops[0] == OP_W);
            chk("avm_read", avm.avm_read, ops.size() != 0 && ops[0] == OP_R);
            chk("value", value, m_val);
            chk("mismatch", mismatch, m_mis);
            chk("overrun", overrun, m_ovr);
            if (ops.size() != 0 && ops[0] == OP_W) begin
                chk("writedata", avm.avm_writedata, {28'd0, m_next});
                chk("address", avm.avm_address, 0);
            end
        end
        if (!reset && avm.avm_write && !avm.avm_waitrequest)
            wlog.push_back(avm.avm_writedata[3:0]);

        if (reset) begin
            ops.delete();
            m_cnt = 0; m_val = 0; m_next = 0; m_mis = 0; m_ovr = 0; m_cap = 0;
            m_valid = 1'b1;
        end else begin
            m_tk  = enable && (m_cnt == PERIOD - 1);
            m_cnt = enable ? (m_cnt + 1) % PERIOD : 0;
            m_ev  = m_tk || roll;
            m_bz  = ops.size() != 0;
            m_ms  = 0;
            if (m_bz) begin
                if (ops[0] == OP_W && !wait_r) begin
                    m_val = m_next;
                    void'(ops.pop_front());
                end else if (ops[0] == OP_R && !wait_r) begin
                    m_cap = avm.avm_readdata;
                    void'(ops.pop_front());
                end else if (ops[0] == OP_C) begin
                    m_ms = (m_cap != {28'd0, m_val});
                    void'(ops.pop_front());
                end
            end
            if (m_ev && !m_bz) begin
                m_next = (m_val == 6 || m_val == 0) ? 4'd1 : m_val + 4'd1;
                ops.push_back(OP_W);
                if (RB) begin
                    ops.push_back(OP_R);
                    ops.push_back(OP_C);
                end
            end
            m_ovr = (m_ev && m_bz) ? 1'b1 : (clear_flags ? 1'b0 : m_ovr);
            m_mis = m_ms ? 1'b1 : (clear_flags ? 1'b0 : m_mis);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 100) begin cyc(); k++; end
        if (k >= 100) chk({name, " idle timeout"}, busy, 0);
    endtask

    task automatic pulse_roll();
        roll = 1'b1; cyc(); roll = 1'b0;
    endtask

    int exp1[7] = '{1, 2, 3, 4, 5, 6, 1};

    initial begin
        cyc(2);
        reset = 1'b0;
        chk("rst value", value, 0);
        chk("rst busy", busy, 0);
        chk("rst write", avm.avm_write, 0);
        chk("rst read", avm.avm_read, 0);
        chk("rst overrun", overrun, 0);

        // periodic rolls
        wlog.delete();
        enable = 1'b1; cyc(30); enable = 1'b0;
        wait_idle("t1");
        chk("t1 writes", wlog.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < wlog.size()) chk($sformatf("t1 write%0d", i), wlog[i], exp1[i]);
        chk("t1 value", value, 1);
        chk("t1 mismatch", mismatch, 0);

        // single roll latency
        cyc(2);
        wlog.delete();
        pulse_roll();
        chk("t2 write n+1", avm.avm_write, 1);
        chk("t2 busy n+1", busy, 1);
        cyc();
        chk("t2 value n+2", value, 2);
        chk("t2 read n+2", avm.avm_read, RB);
        chk("t2 busy n+2", busy, RB);
        if (RB) begin
            cyc(); chk("t2 busy n+3", busy, 1);
            cyc(); chk("t2 busy n+4", busy, 0);
        end
        chk("t2 writes", wlog.size(), 1);
        chk("t2 wdata", wlog.size() > 0 ? wlog[0] : 4'hf, 2);

        // waitrequest stall during WRITE
        cyc(2);
        wait_r = 1'b1;
        pulse_roll();
        for (int i = 0; i < 3; i++) begin
            chk("t3 write held", avm.avm_write, 1);
            chk("t3 wdata", avm.avm_writedata, 3);
            chk("t3 value held", value, 2);
            cyc();
        end
        wait_r = 1'b0;
        cyc();
        chk("t3 value", value, 3);
        wait_idle("t3");

        // corrupt readback of value 3
        corrupt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pulse_roll(); wait_idle("t4");
        end
        chk("t4 value", value, 3);
        chk("t4 mismatch", mismatch, RB);
        cyc(3);
        chk("t4 sticky", mismatch, RB);
        clear_flags = 1'b1; cyc(); clear_flags = 1'b0;
        chk("t4 cleared", mismatch, 0);
        corrupt = 1'b0;

        // roll while busy
        wlog.delete();
        wait_r = 1'b1;
        pulse_roll(); cyc();
        pulse_roll();
        chk("t5 overrun", overrun, 1);
        cyc(3);
        wait_r = 1'b0;
        wait_idle("t5");
        chk("t5 writes", wlog.size(), 1);
        clear_flags = 1'b1; cyc(); clear_flags = 1'b0;
        chk("t5 cleared", overrun, 0);

        // reset mid-WRITE
        wait_r = 1'b1;
        pulse_roll();
        chk("t6 in write", avm.avm_write, 1);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("t6 write", avm.avm_write, 0);
        chk("t6 value", value, 0);
        chk("t6 busy", busy, 0);
        wait_r = 1'b0;
        wlog.delete();
        pulse_roll(); wait_idle("t6");
        chk("t6 first", wlog.size() > 0 ? wlog[0] : 4'hf, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) enable = ~enable;
            roll        = ($urandom_range(9) == 0);
            clear_flags = ($urandom_range(29) == 0);
            wait_r      = ($urandom_range(2) == 0);
            if ($urandom_range(49) == 0) corrupt = ~corrupt;
            reset       = ($urandom_range(299) == 0);
            cyc();
        end
        enable = 1'b0; roll = 1'b0; clear_flags = 1'b0; wait_r = 1'b0; reset = 1'b0;
        cyc();
        wait_idle("rand");
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
